// File: rtl/hazard_controller.sv
// Hazard and stall controller for a 5-stage RISC-V pipeline: E-stage forwarding, load-use
// stalls, branch/jump flushes and a memory-wait FSM with timeout fault. Define PERF_CNT_EN for perf counters.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic [1:0]       result_src_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             pc_src_e,
  input  logic             mem_access_m,
  input  logic             dmem_ready,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             fault,
  output logic [CNT_W-1:0] perf_lu_stalls,
  output logic [CNT_W-1:0] perf_mem_stalls,
  output logic [CNT_W-1:0] perf_flushes
);

  localparam int              WC_W       = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LIMIT   = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_MAX     = '1;
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            lu;
  logic            ms;

  // M-stage producer is younger than W, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                         input logic wm, input logic [4:0] rdw, input logic ww);
    if (rs == 5'd0)             return 2'b00;
    else if (wm && (rdm == rs)) return 2'b10;
    else if (ww && (rdw == rs)) return 2'b01;
    else                        return 2'b00;
  endfunction

  assign lu = (result_src_e == 2'b01) && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign ms = mem_access_m && !dmem_ready;

  // NOTE: state flops use non-blocking assignments and an asynchronous active-low reset so every
  // flop samples the pre-edge values and reset takes effect without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ms) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (ms && TIMEOUT_EN && (wait_cnt == WC_LIMIT)) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (ms) begin
            if (wait_cnt != WC_MAX) wait_cnt <= wait_cnt + 1'b1;
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        FAULT: fault <= 1'b1;
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no branch below can infer a latch.
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    if (!reset_n) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else begin
      forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
      forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
      if (state == FAULT) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        // A memory stall freezes E, so a pending branch flush waits until ms drops.
        stall_f = ms | lu;
        stall_d = ms | lu;
        stall_e = ms;
        stall_m = ms;
        flush_w = ms;
        flush_d = pc_src_e & !ms;
        flush_e = (pc_src_e | lu) & !ms;
      end
    end
  end

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             active;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] ms_cnt;
  logic [CNT_W-1:0] fl_cnt;

  assign active = (state != FAULT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lu_cnt <= '0;
      ms_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      if (active && lu && !ms && !pc_src_e && (lu_cnt != CNT_MAX)) lu_cnt <= lu_cnt + 1'b1;
      if (active && ms && (ms_cnt != CNT_MAX))                      ms_cnt <= ms_cnt + 1'b1;
      if (flush_d && (fl_cnt != CNT_MAX))                           fl_cnt <= fl_cnt + 1'b1;
    end
  end

  assign perf_lu_stalls  = lu_cnt;
  assign perf_mem_stalls = ms_cnt;
  assign perf_flushes    = fl_cnt;
`else
  assign perf_lu_stalls  = '0;
  assign perf_mem_stalls = '0;
  assign perf_flushes    = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the pipeline hazard rules.
module tb_hazard_controller;

  localparam int TIMEOUT = 4;
  localparam int CW      = 4;
  localparam int SAT     = (1 << CW) - 1;
  localparam logic [11:0] RESET_OUTS = 12'b00_00_0000_111_0;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]    result_src_e;
  logic          reg_write_m, reg_write_w, pc_src_e, mem_access_m, dmem_ready;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, fault;
  logic [CW-1:0] perf_lu_stalls, perf_mem_stalls, perf_flushes;

  int errors = 0;
  int checks = 0;

  // Model state: consecutive memory-stall cycles, sticky fault, event counts.
  int m_consec;
  bit m_faulted;
  int m_lu, m_ms, m_fl;

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .result_src_e(result_src_e),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
    .mem_access_m(mem_access_m), .dmem_ready(dmem_ready),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w), .fault(fault),
    .perf_lu_stalls(perf_lu_stalls), .perf_mem_stalls(perf_mem_stalls), .perf_flushes(perf_flushes)
  );

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (reg_write_m && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit lu_ref();
    return (result_src_e == 2'b01) && (rd_e != 5'd0) && (rd_e == rs1_d || rd_e == rs2_d);
  endfunction

  function automatic bit ms_ref();
    return mem_access_m && !dmem_ready;
  endfunction

  // Packed view: {fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, fault}
  function automatic logic [11:0] outs();
    return {forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
            flush_d, flush_e, flush_w, fault};
  endfunction

  function automatic logic [11:0] expect_outs();
    bit lu, ms;
    logic pipe_stall;
    lu = lu_ref();
    ms = ms_ref();
    if (!reset_n) return RESET_OUTS;
    if (m_faulted) return {fwd_ref(rs1_e), fwd_ref(rs2_e), 4'b1111, 3'b001, 1'b1};
    pipe_stall = ms || lu;
    return {fwd_ref(rs1_e), fwd_ref(rs2_e), pipe_stall, pipe_stall, logic'(ms), logic'(ms),
            logic'(pc_src_e && !ms), logic'((pc_src_e || lu) && !ms), logic'(ms), 1'b0};
  endfunction

  function automatic logic [3*CW-1:0] perf_obs();
    return {perf_lu_stalls, perf_mem_stalls, perf_flushes};
  endfunction

  function automatic logic [3*CW-1:0] perf_exp();
`ifdef PERF_CNT_EN
    return {CW'(m_lu), CW'(m_ms), CW'(m_fl)};
`else
    return '0;
`endif
  endfunction

  function automatic int sat_inc(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    m_consec = 0; m_faulted = 0; m_lu = 0; m_ms = 0; m_fl = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit lu, ms;
    if (!reset_n || m_faulted) return;
    lu = lu_ref();
    ms = ms_ref();
    if (ms) begin
      m_ms = sat_inc(m_ms);
      m_consec++;
      if (TIMEOUT != 0 && m_consec > TIMEOUT) m_faulted = 1;
    end else begin
      m_consec = 0;
    end
    if (lu && !ms && !pc_src_e) m_lu = sat_inc(m_lu);
    if (pc_src_e && !ms) m_fl = sat_inc(m_fl);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    result_src_e = 2'b00; reg_write_m = 0; reg_write_w = 0;
    pc_src_e = 0; mem_access_m = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle();
    #1;
  endtask

  task automatic test_reset();
    rs1_e = 5; rs2_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 3; reg_write_w = 1;
    rs1_d = 6; rs2_d = 6; rd_e = 6; result_src_e = 2'b01; rd_m = 5;
    pc_src_e = 1; mem_access_m = 1; dmem_ready = 0;
    model_clear();
    #1;
    checks++;
    if (outs() !== RESET_OUTS) begin
      errors++; $display("FAIL reset_outs: got %b want %b", outs(), RESET_OUTS);
    end
    checks++;
    if (perf_obs() !== '0) begin
      errors++; $display("FAIL reset_perf: got %h want 0", perf_obs());
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    #1;
    checks++;
    if (outs() !== 12'b0) begin
      errors++; $display("FAIL post_reset_idle: got %b want %b", outs(), 12'b0);
    end
  endtask

  task automatic test_forwarding();
    reg_write_m = 1; rd_m = 5; reg_write_w = 1; rd_w = 5; rs1_e = 5;
    #1;
    checks++;
    if (forward_a_e !== 2'b10) begin
      errors++; $display("FAIL fwd_a_m_priority: got %b want 10", forward_a_e);
    end
    rs1_e = 0;
    #1;
    checks++;
    if (forward_a_e !== 2'b00) begin
      errors++; $display("FAIL fwd_a_x0: got %b want 00", forward_a_e);
    end
    rs1_e = 5; reg_write_m = 0; rs2_e = 5;
    #1;
    checks++;
    if ({forward_a_e, forward_b_e} !== 4'b0101) begin
      errors++; $display("FAIL fwd_w_only: got %b want 0101", {forward_a_e, forward_b_e});
    end
    tick();
    for (int i = 0; i < 40; i++) begin
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_m = 5'($urandom_range(0, 3));  rd_w = 5'($urandom_range(0, 3));
      reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
      #1;
      checks++;
      if (outs() !== expect_outs()) begin
        errors++; $display("FAIL fwd_random[%0d]: got %b want %b", i, outs(), expect_outs());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_load_use();
    result_src_e = 2'b01; rd_e = 6; rs2_d = 6;
    #1;
    checks++;
    if ({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e} !== 6'b110001) begin
      errors++; $display("FAIL load_use: got %b want 110001",
                         {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e});
    end
    tick();
    result_src_e = 2'b00;
    #1;
    checks++;
    if (outs() !== expect_outs()) begin
      errors++; $display("FAIL load_use_release: got %b want %b", outs(), expect_outs());
    end
    result_src_e = 2'b01; rd_e = 0; rs2_d = 0;
    #1;
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin
      errors++; $display("FAIL load_use_x0: got %b want 000", {stall_f, stall_d, flush_e});
    end
    idle();
    tick();
  endtask

  task automatic test_branch_flush();
    pc_src_e = 1;
    #1;
    checks++;
    if (outs() !== 12'b00_00_0000_110_0) begin
      errors++; $display("FAIL branch_flush: got %b want %b", outs(), 12'b00_00_0000_110_0);
    end
    tick();
    result_src_e = 2'b01; rd_e = 7; rs1_d = 7;
    #1;
    checks++;
    if ({flush_d, flush_e} !== 2'b11) begin
      errors++; $display("FAIL branch_plus_lu: got %b want 11", {flush_d, flush_e});
    end
    checks++;
    if (outs() !== expect_outs()) begin
      errors++; $display("FAIL branch_plus_lu_all: got %b want %b", outs(), expect_outs());
    end
    tick();
    idle();
  endtask

  task automatic test_mem_wait();
    mem_access_m = 1; dmem_ready = 0; pc_src_e = 1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++;
      if (outs() !== 12'b00_00_1111_001_0) begin
        errors++; $display("FAIL mem_wait_cyc%0d: got %b want %b", c, outs(), 12'b00_00_1111_001_0);
      end
      tick();
    end
    dmem_ready = 1;
    #1;
    checks++;
    if (outs() !== 12'b00_00_0000_110_0) begin
      errors++; $display("FAIL mem_wait_done: got %b want %b", outs(), 12'b00_00_0000_110_0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (outs() !== 12'b0) begin
      errors++; $display("FAIL mem_wait_run: got %b want 0", outs());
    end
  endtask

  task automatic test_timeout_fault();
    mem_access_m = 1; dmem_ready = 0;
    for (int c = 1; c <= TIMEOUT + 1; c++) begin
      #1;
      checks++;
      if ({stall_m, fault} !== 2'b10) begin
        errors++; $display("FAIL timeout_pre_cyc%0d: got %b want 10", c, {stall_m, fault});
      end
      tick();
    end
    pc_src_e = 1; dmem_ready = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (outs() !== 12'b00_00_1111_001_1) begin
        errors++; $display("FAIL fault_held%0d: got %b want %b", c, outs(), 12'b00_00_1111_001_1);
      end
      tick();
    end
    #3;
    reset_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (outs() !== RESET_OUTS) begin
      errors++; $display("FAIL fault_async_reset: got %b want %b", outs(), RESET_OUTS);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    mem_access_m = 1; dmem_ready = 0;
    #1;
    checks++;
    if (outs() !== 12'b00_00_1111_001_0) begin
      errors++; $display("FAIL after_fault_run: got %b want %b", outs(), 12'b00_00_1111_001_0);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_perf();
    do_reset();
    result_src_e = 2'b01; rd_e = 6; rs2_d = 6; tick(); idle();
    pc_src_e = 1; tick();
    result_src_e = 2'b01; rd_e = 6; rs2_d = 6; tick(); idle();
    mem_access_m = 1; dmem_ready = 0; pc_src_e = 1; repeat (3) tick();
    dmem_ready = 1; tick(); idle();
    #1;
    checks++;
    if (perf_obs() !== perf_exp()) begin
      errors++; $display("FAIL perf_scenarios: got %h want %h", perf_obs(), perf_exp());
    end
    do_reset();
    pc_src_e = 1;
    repeat (SAT + 5) tick();
    idle();
    #1;
    checks++;
`ifdef PERF_CNT_EN
    if (perf_flushes !== CW'(SAT)) begin
      errors++; $display("FAIL perf_saturate: got %0d want %0d", perf_flushes, SAT);
    end
`else
    if (perf_flushes !== '0) begin
      errors++; $display("FAIL perf_disabled: got %0d want 0", perf_flushes);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bool_phase: begin end
      rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
      rs1_e = 5'($urandom_range(0, 7)); rs2_e = 5'($urandom_range(0, 7));
      rd_e  = 5'($urandom_range(0, 7)); rd_m  = 5'($urandom_range(0, 7));
      rd_w  = 5'($urandom_range(0, 7));
      result_src_e = 2'($urandom_range(0, 3));
      reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
      pc_src_e = ($urandom_range(0, 3) == 0);
      mem_access_m = ($urandom_range(0, 3) != 0);
      dmem_ready = ((i / 100) % 2 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 4) != 0);
      reset_n = ($urandom_range(0, 59) != 0);
      if (!reset_n) model_clear();
      #1;
      checks++;
      if (outs() !== expect_outs()) begin
        errors++; $display("FAIL random_outs[%0d]: got %b want %b", i, outs(), expect_outs());
      end
      checks++;
      if (perf_obs() !== perf_exp()) begin
        errors++; $display("FAIL random_perf[%0d]: got %h want %h", i, perf_obs(), perf_exp());
      end
      tick();
    end
    reset_n = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_timeout_fault();
    test_perf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
